// File: rtl/or1200_cust5_sponge_ctrl_if.sv
// Block/digest bus between the cust5 sponge controller (master) and the
// external permutation core (slave).
interface or1200_cust5_sponge_ctrl_if #(
    parameter int RATE_WORDS   = 18,
    parameter int DIGEST_WORDS = 16
);
    logic                         blk_valid;
    logic                         blk_ready;
    logic [32*RATE_WORDS-1:0]     blk_data;
    logic                         blk_first;
    logic                         blk_last;
    logic                         dig_valid;
    logic [32*DIGEST_WORDS-1:0]   dig_data;

    modport master (
        output blk_valid, blk_data, blk_first, blk_last,
        input  blk_ready, dig_valid, dig_data
    );

    modport slave (
        input  blk_valid, blk_data, blk_first, blk_last,
        output blk_ready, dig_valid, dig_data
    );
endinterface

// File: rtl/or1200_cust5_sponge_ctrl.sv
// l.cust5 sponge absorb/squeeze controller: packs message words into rate blocks,
// pads on TAIL, hands blocks to the permutation core and returns the digest.
// Optional OR1200_CUST5_DOMAIN_SEL_EN: HEAD limm[5:4] selects the domain pad byte.
module or1200_cust5_sponge_ctrl #(
    parameter int RATE_WORDS   = 18,
    parameter int DIGEST_WORDS = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              op_valid,
    input  logic [4:0]                        cust5_op,
    input  logic [5:0]                        cust5_limm,
    input  logic [31:0]                       operand_a,
    output logic                              busy,
    output logic [31:0]                       result,
    or1200_cust5_sponge_ctrl_if.master        bus
);
    localparam int WCW = $clog2(RATE_WORDS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_DIG = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [4:0] OP_HEAD   = 5'b00100;
    localparam logic [4:0] OP_BODY   = 5'b00010;
    localparam logic [4:0] OP_TAIL   = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_STATUS = 5'b10000;

    logic [2:0]                   state_q, state_d;
    logic [32*RATE_WORDS-1:0]     buf_q, buf_d;
    logic [WCW-1:0]               wc_q, wc_d;
    logic                         first_q, first_d;
    logic                         last_q, last_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [32*DIGEST_WORDS-1:0]   dig_q, dig_d;
    logic [31:0]                  result_q, result_d;
    logic [31:0]                  tail_word;
    logic                         op_onehot;
    logic                         op_acc;

`ifdef OR1200_CUST5_DOMAIN_SEL_EN
    logic [7:0] dsep_q, dsep_d;
`else
    logic [7:0] dsep_q;
    assign dsep_q = 8'h06;
`endif

    assign op_onehot = (cust5_op != '0) && ((cust5_op & (cust5_op - 5'd1)) == '0);
    assign op_acc    = op_valid && !busy && op_onehot;

    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT_DIG);
    assign result        = result_q;
    assign bus.blk_valid = (state_q == S_ISSUE);
    assign bus.blk_data  = buf_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;

    // Top n bytes of the operand, then the domain pad byte, then zeros.
    always_comb begin
        tail_word = '0;
        case (cust5_limm[1:0])
            2'd0:    tail_word = {dsep_q, 24'h0};
            2'd1:    tail_word = {operand_a[31:24], dsep_q, 16'h0};
            2'd2:    tail_word = {operand_a[31:16], dsep_q, 8'h0};
            default: tail_word = {operand_a[31:8], dsep_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        wc_d     = wc_q;
        first_d  = first_q;
        last_d   = last_q;
        done_d   = done_q;
        err_d    = err_q;
        dig_d    = dig_q;
        result_d = result_q;
`ifdef OR1200_CUST5_DOMAIN_SEL_EN
        dsep_d   = dsep_q;
`endif
        case (state_q)
            S_ISSUE: begin
                if (bus.blk_ready) begin
                    first_d = 1'b0;
                    state_d = S_WAIT_DIG;
                end
            end
            S_WAIT_DIG: begin
                if (bus.dig_valid) begin
                    if (last_q) begin
                        dig_d   = bus.dig_data;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        wc_d    = '0;
                        buf_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                if (op_acc) begin
                    case (cust5_op)
                        OP_HEAD: begin
                            buf_d   = '0;
                            wc_d    = '0;
                            done_d  = 1'b0;
                            first_d = 1'b1;
                            state_d = S_FILL;
`ifdef OR1200_CUST5_DOMAIN_SEL_EN
                            case (cust5_limm[5:4])
                                2'b01:   dsep_d = 8'h1F;
                                2'b10:   dsep_d = 8'h01;
                                default: dsep_d = 8'h06;
                            endcase
`endif
                        end
                        OP_BODY: begin
                            if (state_q == S_FILL) begin
                                for (int unsigned i = 0; i < RATE_WORDS; i++)
                                    if (WCW'(i) == wc_q) buf_d[32*i +: 32] = operand_a;
                                wc_d = wc_q + 1'b1;
                                if (wc_q == WCW'(RATE_WORDS - 1)) begin
                                    last_d  = 1'b0;
                                    state_d = S_ISSUE;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_TAIL: begin
                            if (state_q == S_FILL) begin
                                for (int unsigned i = 0; i < RATE_WORDS; i++) begin
                                    if (WCW'(i) == wc_q)     buf_d[32*i +: 32] = tail_word;
                                    else if (WCW'(i) > wc_q) buf_d[32*i +: 32] = '0;
                                end
                                // OR keeps D intact when it lands in the final byte.
                                buf_d[32*(RATE_WORDS-1) +: 8] = buf_d[32*(RATE_WORDS-1) +: 8] | 8'h80;
                                last_d  = 1'b1;
                                state_d = S_ISSUE;
                            end
                        end
                        OP_STORE: begin
                            result_d = '0;
                            for (int unsigned i = 0; i < DIGEST_WORDS; i++)
                                if (6'(i) == cust5_limm) result_d = dig_q[32*i +: 32];
                        end
                        OP_STATUS: begin
                            result_d = {28'h0, err_q, done_q, (state_q != S_IDLE), first_q};
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            buf_q    <= '0;
            wc_q     <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dig_q    <= '0;
            result_q <= '0;
`ifdef OR1200_CUST5_DOMAIN_SEL_EN
            dsep_q   <= 8'h06;
`endif
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            wc_q     <= wc_d;
            first_q  <= first_d;
            last_q   <= last_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dig_q    <= dig_d;
            result_q <= result_d;
`ifdef OR1200_CUST5_DOMAIN_SEL_EN
            dsep_q   <= dsep_d;
`endif
        end
    end
endmodule

// File: tb/tb_or1200_cust5_sponge_ctrl.sv
// Directed self-checking bench for the cust5 sponge controller.
module tb_or1200_cust5_sponge_ctrl;
    localparam int RW = 18;
    localparam int DW = 16;

    localparam logic [4:0] HEAD   = 5'b00100;
    localparam logic [4:0] BODY   = 5'b00010;
    localparam logic [4:0] TAIL   = 5'b00001;
    localparam logic [4:0] STORE  = 5'b01000;
    localparam logic [4:0] STATUS = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [4:0]  cust5_op;
    logic [5:0]  cust5_limm;
    logic [31:0] operand_a;
    logic        busy;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    logic [31:0] msg [11] = '{32'h54686520, 32'h71756963, 32'h6B206272, 32'h6F776E20,
                              32'h666F7820, 32'h6A756D70, 32'h73206F76, 32'h65722074,
                              32'h6865206C, 32'h617A7920, 32'h646F672E};

    or1200_cust5_sponge_ctrl_if #(.RATE_WORDS(RW), .DIGEST_WORDS(DW)) bus ();

    or1200_cust5_sponge_ctrl #(.RATE_WORDS(RW), .DIGEST_WORDS(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .cust5_op   (cust5_op),
        .cust5_limm (cust5_limm),
        .operand_a  (operand_a),
        .busy       (busy),
        .result     (result),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bw(input int i);
        return bus.blk_data[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a);
        op_valid   = 1'b1;
        cust5_op   = op;
        cust5_limm = limm;
        operand_a  = a;
        tick();
        op_valid   = 1'b0;
    endtask

    task automatic complete_block(input logic [31:0] base);
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
        for (int i = 0; i < DW; i++) bus.dig_data[32*i +: 32] = base + 32'(i);
        bus.dig_valid = 1'b1;
        tick();
        bus.dig_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b expected 0", bus.blk_valid); end
        checks++; if (bus.blk_first !== 1'b0 || bus.blk_last !== 1'b0) begin errors++; $display("FAIL reset_first_last: got %b%b expected 00", bus.blk_first, bus.blk_last); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++; if (bus.blk_data !== '0) begin errors++; $display("FAIL reset_blk_data: got nonzero expected 0"); end
    endtask

    task automatic test_fox_block();
        logic [31:0] exp;
        do_op(HEAD, 6'd0, 32'h0);
        for (int i = 0; i < 11; i++) do_op(BODY, 6'd0, msg[i]);
        do_op(TAIL, 6'd0, 32'h0);
        checks++; if (busy !== 1'b1 || bus.blk_valid !== 1'b1) begin errors++; $display("FAIL fox_issue: got busy=%b valid=%b expected 1 1", busy, bus.blk_valid); end
        checks++; if (bus.blk_first !== 1'b1 || bus.blk_last !== 1'b1) begin errors++; $display("FAIL fox_first_last: got %b%b expected 11", bus.blk_first, bus.blk_last); end
        for (int i = 0; i < RW; i++) begin
            exp = (i < 11) ? msg[i] : (i == 11) ? 32'h06000000 : (i == 17) ? 32'h00000080 : 32'h0;
            checks++; if (bw(i) !== exp) begin errors++; $display("FAIL fox_word%0d: got %h expected %h", i, bw(i), exp); end
        end
        bus.blk_ready = 1'b1;
        tick();
        bus.blk_ready = 1'b0;
        checks++; if (bus.blk_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fox_handshake: got valid=%b busy=%b expected 0 1", bus.blk_valid, busy); end
        for (int i = 0; i < DW; i++) bus.dig_data[32*i +: 32] = 32'h10000000 + 32'(i);
        bus.dig_valid = 1'b1;
        tick();
        bus.dig_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fox_turnaround_busy: got %b expected 0", busy); end
    endtask

    task automatic test_store_status();
        do_op(STORE, 6'd15, 32'h0);
        checks++; if (result !== 32'h1000000F) begin errors++; $display("FAIL store15: got %h expected 1000000f", result); end
        tick();
        tick();
        checks++; if (result !== 32'h1000000F) begin errors++; $display("FAIL store_hold: got %h expected 1000000f", result); end
        do_op(STORE, 6'd0, 32'h0);
        checks++; if (result !== 32'h10000000) begin errors++; $display("FAIL store0: got %h expected 10000000", result); end
        do_op(STORE, 6'd20, 32'h0);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL store20: got %h expected 00000000", result); end
        do_op(STATUS, 6'd0, 32'h0);
        checks++; if (result !== 32'h6) begin errors++; $display("FAIL status_done: got %h expected 00000006", result); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w0;
        do_op(HEAD, 6'd0, 32'h0);
        for (int i = 0; i < 17; i++) do_op(BODY, 6'd0, 32'hA0000000 + 32'(i));
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_not_full: got busy=%b expected 0", busy); end
        do_op(BODY, 6'd0, 32'hA0000011);
        checks++; if (busy !== 1'b1 || bus.blk_valid !== 1'b1) begin errors++; $display("FAIL b2b_issue: got busy=%b valid=%b expected 1 1", busy, bus.blk_valid); end
        checks++; if (bus.blk_last !== 1'b0 || bus.blk_first !== 1'b1) begin errors++; $display("FAIL b2b_flags: got first=%b last=%b expected 1 0", bus.blk_first, bus.blk_last); end
        w0 = bw(0);
        for (int c = 0; c < 5; c++) begin
            do_op((c % 2 == 0) ? BODY : HEAD, 6'd0, 32'hFFFFFFFF);
            checks++; if (bus.blk_valid !== 1'b1 || bw(0) !== 32'hA0000000 || bw(17) !== 32'hA0000011) begin
                errors++; $display("FAIL b2b_stall%0d: got valid=%b w0=%h w17=%h expected 1 a0000000 a0000011", c, bus.blk_valid, bw(0), bw(17)); end
        end
        checks++; if (bw(0) !== w0) begin errors++; $display("FAIL b2b_stable: got %h expected %h", bw(0), w0); end
        complete_block(32'hDEAD0000);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_refill: got busy=%b expected 0", busy); end
        do_op(TAIL, 6'd0, 32'h0);
        checks++; if (bus.blk_first !== 1'b0 || bus.blk_last !== 1'b1) begin errors++; $display("FAIL b2b_second_flags: got first=%b last=%b expected 0 1", bus.blk_first, bus.blk_last); end
        checks++; if (bw(0) !== 32'h06000000 || bw(1) !== 32'h0 || bw(17) !== 32'h80) begin
            errors++; $display("FAIL b2b_second_data: got w0=%h w1=%h w17=%h expected 06000000 00000000 00000080", bw(0), bw(1), bw(17)); end
        complete_block(32'h20000000);
        do_op(STORE, 6'd3, 32'h0);
        checks++; if (result !== 32'h20000003) begin errors++; $display("FAIL b2b_store3: got %h expected 20000003", result); end
    endtask

    task automatic test_tail_bytes();
        do_op(HEAD, 6'd0, 32'h0);
        for (int i = 0; i < 17; i++) do_op(BODY, 6'd0, 32'h11111111);
        do_op(TAIL, 6'd3, 32'h41424344);
        checks++; if (bw(17) !== 32'h41424386) begin errors++; $display("FAIL tail3_w17: got %h expected 41424386", bw(17)); end
        checks++; if (bw(16) !== 32'h11111111) begin errors++; $display("FAIL tail3_w16: got %h expected 11111111", bw(16)); end
        complete_block(32'h0);
        do_op(HEAD, 6'd0, 32'h0);
        do_op(TAIL, 6'd1, 32'hAABBCCDD);
        checks++; if (bw(0) !== 32'hAA060000 || bw(17) !== 32'h80) begin errors++; $display("FAIL tail1: got w0=%h w17=%h expected aa060000 00000080", bw(0), bw(17)); end
        complete_block(32'h0);
        do_op(HEAD, 6'd0, 32'h0);
        do_op(BODY, 6'd0, 32'h12345678);
        do_op(TAIL, 6'd2, 32'hAABBCCDD);
        checks++; if (bw(0) !== 32'h12345678 || bw(1) !== 32'hAABB0600) begin errors++; $display("FAIL tail2: got w0=%h w1=%h expected 12345678 aabb0600", bw(0), bw(1)); end
        complete_block(32'h0);
    endtask

    task automatic test_err_and_ignore();
        do_reset();
        do_op(HEAD | BODY, 6'd0, 32'h0);
        do_op(STATUS, 6'd0, 32'h0);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL multi_hot_ignored: got %h expected 00000000", result); end
        do_op(BODY, 6'd0, 32'h12345678);
        do_op(TAIL, 6'd0, 32'h0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tail_idle_ignored: got busy=%b expected 0", busy); end
        do_op(STATUS, 6'd0, 32'h0);
        checks++; if (result !== 32'h8) begin errors++; $display("FAIL status_err: got %h expected 00000008", result); end
    endtask

    task automatic test_rst_in_issue();
        do_op(HEAD, 6'd0, 32'h0);
        do_op(STATUS, 6'd0, 32'h0);
        checks++; if (result !== 32'hB) begin errors++; $display("FAIL status_fill: got %h expected 0000000b", result); end
        do_op(TAIL, 6'd0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.blk_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_issue: got valid=%b busy=%b expected 0 0", bus.blk_valid, busy); end
        bus.dig_valid = 1'b1;
        tick();
        bus.dig_valid = 1'b0;
        do_op(STATUS, 6'd0, 32'h0);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_dig_ignored: got %h expected 00000000", result); end
    endtask

    task automatic test_domain_sel();
        logic [31:0] exp;
`ifdef OR1200_CUST5_DOMAIN_SEL_EN
        exp = 32'h1F000000;
`else
        exp = 32'h06000000;
`endif
        do_op(HEAD, 6'h10, 32'h0);
        do_op(TAIL, 6'd0, 32'h0);
        checks++; if (bw(0) !== exp) begin errors++; $display("FAIL domain_sel: got %h expected %h", bw(0), exp); end
        complete_block(32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        op_valid      = 1'b0;
        cust5_op      = '0;
        cust5_limm    = '0;
        operand_a     = '0;
        bus.blk_ready = 1'b0;
        bus.dig_valid = 1'b0;
        bus.dig_data  = '0;
        test_reset();
        test_fox_block();
        test_store_status();
        test_back_to_back();
        test_tail_bytes();
        test_err_and_ignore();
        test_rst_in_issue();
        test_domain_sel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
